multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory-wait cycles tolerated per access before a timeout error (1..255).
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: op, funct  in  6 each  opcode and function fields from the instruction register.
REQ-006 Port: zero  in  1  ALU zero flag.
REQ-007 Port: memready  in  1  memory acknowledge; completes the current access in the cycle it is high.
REQ-008 Ports: pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zeroext, memreq  out  1 each  datapath controls; zeroext selects zero-extended immediate; memreq marks an active memory access.
REQ-009 Ports: alusrcb, pcsrc  out  2 each; alucontrol  out  3  datapath selects.
REQ-010 Ports: state  out  4  current state; retired  out  CNT_W  retired-instruction count; illegal, memerr  out  1 each  sticky error flags.

Function
REQ-011 States (4'd): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, BNEEX 12, ERROR 15.
REQ-012 DECODE transitions: lw/sw (100011/101011) to MEMADR; R-type (000000) to RTYPEEX; beq (000100) to BEQEX; addi/andi/ori/slti (001000/001100/001101/001010) to IMMEX; j (000010) to JEX; bne (000101) to BNEEX when enabled; any other opcode to ERROR with illegal set.
REQ-013 Fixed transitions: MEMADR to MEMRD (lw) or MEMWR (sw); MEMRD to MEMWB; RTYPEEX to RTYPEWB; IMMEX to IMMWB; MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX to FETCH.
REQ-014 FETCH, MEMRD, MEMWR are memory states: memreq=1, and the state is held until memready=1.
REQ-015 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010; irwrite and pcen are 1 only in the cycle memready=1.
REQ-016 MEMWR: iord=1 and memwrite=1 every cycle in the state; MEMRD: iord=1, writes nothing.
REQ-017 DECODE: alusrca=0, alusrcb=11, alucontrol=010. MEMADR: alusrca=1, alusrcb=10, alucontrol=010.
REQ-018 MEMWB: regwrite=1, memtoreg=1, regdst=0. RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111, otherwise to ERROR with illegal set). RTYPEWB: regwrite=1, regdst=1, memtoreg=0.
REQ-019 IMMEX: alusrca=1, alusrcb=10; alucontrol is 010 for addi, 000 for andi, 001 for ori, 111 for slti; zeroext=1 only for andi/ori. IMMWB: regwrite=1, regdst=0, memtoreg=0.
REQ-020 BEQEX/BNEEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01; pcen=zero (BEQEX) or pcen=~zero (BNEEX). JEX: pcsrc=10, pcen=1.
REQ-021 All outputs not stated for a state are 0; pcen is combinational from state, memready and zero.
REQ-022 Wait counter: cleared on entry to each memory state and incremented every cycle memready=0 there; when it reaches MAX_WAIT with memready still 0, next state is ERROR with memerr set. memready=1 in that same cycle wins (normal advance).
REQ-023 ERROR: all controls 0, memreq=0, and the state is held until reset; illegal/memerr stay set until reset.
REQ-024 retired increments by 1 on every transition into FETCH and wraps modulo 2^CNT_W; it does not increment on entry to ERROR.

Reset
REQ-025 reset asserted at any time, including mid-access: state=FETCH, wait counter=0, retired=0, illegal=0, memerr=0, all outputs at their FETCH values with memready low. The first rising edge after deassertion evaluates from FETCH.

Configuration
REQ-026 Macro MULTICYCLE_CONTROLLER_BNE_EN defined: bne decodes to BNEEX as specified. Macro undefined: state 12 is unreachable and opcode 000101 decodes as illegal (ERROR, illegal=1).

Verification
REQ-027 lw with memready=1 every cycle -> FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH in 5 cycles; retired 0 to 1; regwrite=memtoreg=1 only in MEMWB.
REQ-028 sw with memready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; memerr=0.
REQ-029 beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; with the macro defined, bne inverts both cases.
REQ-030 ori, andi -> alucontrol 001 and zeroext=1, then 000 and zeroext=1; slti -> alucontrol 111, zeroext=0; each completes in 4 cycles.
REQ-031 memready held 0 in FETCH with MAX_WAIT=15 -> ERROR after 15 waiting cycles, memerr=1, held until reset; opcode 111111 -> ERROR from DECODE with illegal=1.
REQ-032 reset pulsed during MEMRD with retired=5 -> state=0 and retired=0 immediately (asynchronous); normal fetch resumes.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM with memory wait timeout, retire counter, sticky errors.
// Optional bne support is compiled in with MULTICYCLE_CONTROLLER_BNE_EN.
module multicycle_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memready,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             zeroext,
  output logic             memreq,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             memerr
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,  S_IMMEX   = 4'd9,  S_IMMWB  = 4'd10, S_JEX   = 4'd11,
    S_BNEEX   = 4'd12, S_ERROR   = 4'd15
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             memerr_q, memerr_d;
  logic             timeout;

  assign timeout = (wait_q == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      memerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      memerr_q  <= memerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    memerr_d   = memerr_q;
    retired_d  = retired_q;
    pcen       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    zeroext    = 1'b0;
    memreq     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;

    // Memory states share the wait/timeout handling; the wait counter is zero outside them.
    if (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) begin
      memreq = 1'b1;
      if (!memready) begin
        if (timeout) begin
          state_d  = S_ERROR;
          memerr_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
    end

    case (state_q)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite    = memready;
        pcen       = memready;
        if (memready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          6'b100011, 6'b101011:                       state_d = S_MEMADR;
          6'b000000:                                  state_d = S_RTYPEEX;
          6'b000100:                                  state_d = S_BEQEX;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = S_IMMEX;
          6'b000010:                                  state_d = S_JEX;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
          6'b000101:                                  state_d = S_BNEEX;
`endif
          default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        state_d = S_RTYPEWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IMMWB;
        case (op)
          6'b001000: alucontrol = 3'b010;
          6'b001100: begin alucontrol = 3'b000; zeroext = 1'b1; end
          6'b001101: begin alucontrol = 3'b001; zeroext = 1'b1; end
          6'b001010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_d    = S_FETCH;
      end
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = ~zero;
        state_d    = S_FETCH;
      end
`endif
      S_JEX: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    if (state_d == S_FETCH && state_q != S_FETCH) retired_d = retired_q + 1'b1;
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign memerr  = memerr_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized instruction-level bench against a path-table model of the controller.
module tb_multicycle_controller;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_J = 6'b000010,
                         OP_BNE = 6'b000101;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, memready = 1'b0;
  logic pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zeroext, memreq;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  logic illegal, memerr;

  multicycle_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .zeroext(zeroext), .memreq(memreq), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state), .retired(retired),
    .illegal(illegal), .memerr(memerr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zeroext, memreq;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct {
    int st;
    bit mr;
    bit z;
  } step_t;

  ctrl_t act_ctrl;
  assign act_ctrl = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                     zeroext, memreq, alusrcb, pcsrc, alucontrol};

  step_t path[$];
  int end_kind;  // 0 completes, 1 illegal, 2 memory timeout
  int n_ret = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic [3:0] e_state;
  ctrl_t e_ctrl;
  logic [CNT_W-1:0] e_ret;
  logic e_ill, e_merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic int i_alu(input logic [5:0] o);
    case (o)
      OP_ADDI: return 2;
      OP_ANDI: return 0;
      OP_ORI:  return 1;
      OP_SLTI: return 7;
      default: return -1;
    endcase
  endfunction

  // Expected datapath controls for one cycle, straight from the per-state control table.
  function automatic ctrl_t model_ctrl(input int st, input logic [5:0] o, input logic [5:0] f,
                                       input bit z, input bit mr);
    ctrl_t c = '0;
    case (st)
      0:  begin c.memreq = 1; c.alusrcb = 2'b01; c.alucontrol = 3'b010; c.irwrite = mr; c.pcen = mr; end
      1:  begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
      3:  begin c.memreq = 1; c.iord = 1; end
      4:  begin c.regwrite = 1; c.memtoreg = 1; end
      5:  begin c.memreq = 1; c.iord = 1; c.memwrite = 1; end
      6:  begin c.alusrca = 1; c.alucontrol = (r_alu(f) < 0) ? 3'b000 : 3'(r_alu(f)); end
      7:  begin c.regwrite = 1; c.regdst = 1; end
      8:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      9:  begin
            c.alusrca = 1; c.alusrcb = 2'b10;
            c.alucontrol = (i_alu(o) < 0) ? 3'b000 : 3'(i_alu(o));
            c.zeroext = (o == OP_ANDI || o == OP_ORI);
          end
      10: c.regwrite = 1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1; end
      12: begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = !z; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit zval(input int zm);
    return (zm == 2) ? bit'($urandom_range(0, 1)) : bit'(zm);
  endfunction

  task automatic push(input int st, input bit mr, input int zm);
    step_t s;
    s.st = st; s.mr = mr; s.z = zval(zm);
    path.push_back(s);
  endtask

  task automatic add_mem(input int st, input int w, input int zm, output bit err);
    err = (w >= MAX_WAIT);
    if (err) begin
      for (int k = 0; k < MAX_WAIT; k++) push(st, 1'b0, zm);
    end else begin
      for (int k = 0; k < w; k++) push(st, 1'b0, zm);
      push(st, 1'b1, zm);
    end
  endtask

  // Instruction -> sequence of (state, memready, zero) cycles.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm, input int zm);
    bit err;
    path.delete();
    end_kind = 0;
    add_mem(0, wf, zm, err);
    if (err) end_kind = 2;
    else begin
      push(1, bit'($urandom_range(0, 1)), zm);
      if (o == OP_LW || o == OP_SW) begin
        push(2, bit'($urandom_range(0, 1)), zm);
        add_mem((o == OP_LW) ? 3 : 5, wm, zm, err);
        if (err) end_kind = 2;
        else if (o == OP_LW) push(4, bit'($urandom_range(0, 1)), zm);
      end else if (o == OP_R) begin
        push(6, bit'($urandom_range(0, 1)), zm);
        if (r_alu(f) < 0) end_kind = 1;
        else push(7, bit'($urandom_range(0, 1)), zm);
      end else if (o == OP_BEQ) push(8, bit'($urandom_range(0, 1)), zm);
      else if (i_alu(o) >= 0) begin
        push(9, bit'($urandom_range(0, 1)), zm);
        push(10, bit'($urandom_range(0, 1)), zm);
      end else if (o == OP_J) push(11, bit'($urandom_range(0, 1)), zm);
      else if (o == OP_BNE && BNE_EN) push(12, bit'($urandom_range(0, 1)), zm);
      else end_kind = 1;
    end
    if (end_kind != 0) repeat (3) push(15, bit'($urandom_range(0, 1)), zm);
  endtask

  task automatic do_reset();
    ctrl_t c = '0;
    chk_en = 1'b0;
    reset = 1'b1;
    memready = 1'b0;
    #1;
    c.memreq = 1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_flags", {30'd0, illegal, memerr}, 32'd0);
    chk("rst_ctrl", 32'(act_ctrl), 32'(c));
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_ret = 0;
  endtask

  // Called mid-cycle before the negedge; leaves the bench mid-cycle after the following posedge.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input int rst_at);
    for (int i = 0; i < path.size(); i++) begin
      op = o; funct = f; memready = path[i].mr; zero = path[i].z;
      e_state = 4'(path[i].st);
      e_ctrl  = model_ctrl(path[i].st, o, f, path[i].z, path[i].mr);
      e_ret   = CNT_W'(n_ret);
      e_ill   = (path[i].st == 15 && end_kind == 1);
      e_merr  = (path[i].st == 15 && end_kind == 2);
      chk_en  = 1'b1;
      @(negedge clk);
      if (i == rst_at) begin
        #2;
        do_reset();
        return;
      end
      @(posedge clk);
      #1;
    end
    if (end_kind != 0) do_reset();
    else n_ret++;
  endtask

  task automatic exec(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm, input int zm);
    build(o, f, wf, wm, zm);
    run(o, f, -1);
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("state", 32'(state), 32'(e_state));
      chk("ctrl", 32'(act_ctrl), 32'(e_ctrl));
      chk("retired", 32'(retired), 32'(e_ret));
      chk("flags", {30'd0, illegal, memerr}, {30'd0, e_ill, e_merr});
    end
  end

  function automatic int rwait();
    int r = $urandom_range(0, 39);
    if (r == 0) return MAX_WAIT;
    if (r < 4) return MAX_WAIT - 1;
    return r % 4;
  endfunction

  initial begin
    int seq;
    int cnt;
    logic [5:0] o, f;
    ctrl_t c;
    #2;
    do_reset();

    build(OP_LW, 6'd0, 0, 0, 2);
    seq = 0;
    foreach (path[i]) seq = seq * 16 + path[i].st;
    chk("lw_len", 32'(path.size()), 32'd5);
    chk("lw_seq", 32'(seq), 32'h01234);
    run(OP_LW, 6'd0, -1);
    chk("lw_retired", 32'(retired), 32'd1);

    build(OP_SW, 6'd0, 0, 3, 2);
    cnt = 0;
    foreach (path[i]) if (path[i].st == 5) cnt++;
    chk("sw_memwr_cycles", 32'(cnt), 32'd4);
    run(OP_SW, 6'd0, -1);
    chk("sw_memerr", 32'(memerr), 32'd0);
    chk("sw_state", 32'(state), 32'd0);

    exec(OP_BEQ, 6'd0, 0, 0, 1);
    exec(OP_BEQ, 6'd0, 0, 0, 0);
    exec(OP_BNE, 6'd0, 0, 0, 1);
    if (BNE_EN) begin
      exec(OP_BNE, 6'd0, 0, 0, 0);
    end

    exec(OP_R, 6'b100010, 1, 0, 2);
    foreach (o[i]) o[i] = 1'b0;
    o = OP_ORI;
    c = model_ctrl(9, o, 6'd0, 1'b0, 1'b0);
    chk("ori_model", {28'd0, c.zeroext, c.alucontrol}, 32'h9);
    build(o, 6'd0, 0, 0, 2);
    chk("ori_len", 32'(path.size()), 32'd4);
    run(o, 6'd0, -1);
    o = OP_ANDI;
    c = model_ctrl(9, o, 6'd0, 1'b0, 1'b0);
    chk("andi_model", {28'd0, c.zeroext, c.alucontrol}, 32'h8);
    exec(o, 6'd0, 0, 0, 2);
    o = OP_SLTI;
    c = model_ctrl(9, o, 6'd0, 1'b0, 1'b0);
    chk("slti_model", {28'd0, c.zeroext, c.alucontrol}, 32'h7);
    exec(o, 6'd0, 0, 0, 2);

    exec(OP_LW, 6'd0, 0, MAX_WAIT - 1, 2);

    build(OP_J, 6'd0, MAX_WAIT, 0, 2);
    cnt = 0;
    foreach (path[i]) if (path[i].st == 0) cnt++;
    chk("timeout_fetch_cycles", 32'(cnt), 32'd15);
    chk("timeout_len", 32'(path.size()), 32'd18);
    run(OP_J, 6'd0, -1);

    exec(6'b111111, 6'd0, 0, 0, 2);
    exec(OP_R, 6'b111111, 0, 0, 2);

    repeat (20) exec(OP_J, 6'd0, 0, 0, 2);
    chk("retired_wrap", 32'(retired), 32'd4);

    do_reset();
    repeat (5) exec(OP_J, 6'd0, 0, 0, 2);
    chk("pre_rst_retired", 32'(retired), 32'd5);
    build(OP_LW, 6'd0, 0, 2, 2);
    run(OP_LW, 6'd0, 3);
    exec(OP_LW, 6'd0, 1, 1, 2);
    chk("post_rst_retired", 32'(retired), 32'd1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 10))
        0: o = OP_LW;   1: o = OP_SW;   2: o = OP_R;    3: o = OP_BEQ;
        4: o = OP_ADDI; 5: o = OP_ANDI; 6: o = OP_ORI;  7: o = OP_SLTI;
        8: o = OP_J;    9: o = OP_BNE;
        default: o = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
      else begin
        case ($urandom_range(0, 4))
          0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
          3: f = 6'b100101; default: f = 6'b101010;
        endcase
      end
      exec(o, f, rwait(), rwait(), 2);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
